// File: rtl/demo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demo_ctrl_pkg
// Description : Shared types and constants for the demo run sequencer.
//               Holds the FSM state encoding, the demo datapath width, the
//               counter value that precedes a wrap, and a helper that sizes
//               the settle/run counters from their parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package demo_ctrl_pkg;

    // Width of the test_demo counter output.
    localparam int DEMO_W = 8;

    // Counter value immediately before a wrap to zero.
    localparam logic [DEMO_W-1:0] WRAP_VAL = 8'hFF;

    // Sequencer states. Encodings are visible on state_o for debug, so the
    // values are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    // Counter width able to hold the larger of two terminal counts with one
    // spare bit, so neither counter can wrap before its terminal compare.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage : demo_ctrl_pkg
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Multi-flop synchronizer for a single asynchronous level.
//               The output is the last flop of a STAGES-deep shift chain;
//               every flop clears to 0 on reset.
// Ports       : clk   - destination clock
//               reset - asynchronous active-high reset
//               d     - asynchronous input level
//               q     - synchronized level (STAGES clk edges of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/demo_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : demo_run_ctrl
// Description : Run sequencer for the test_demo counter datapath. Waits for
//               the clock IP lock, requires SETTLE_CYCLES of continuous lock,
//               then holds demo_enable high for RUN_CYCLES. Counts 0xFF->0x00
//               wraps of the demo counter during the run and reports done,
//               busy and a sticky lock-lost fault.
// Ports       : clk         - system clock
//               reset       - asynchronous active-high reset
//               start       - run request (sampled every cycle)
//               stop        - abort request, dominates start
//               ip_locked   - clock IP lock, asynchronous to clk
//               demo_out    - test_demo counter output
//               demo_enable - registered enable to test_demo
//               busy        - high in WAIT_LOCK, SETTLE and RUN
//               done        - one-cycle pulse when a full run completes
//               lock_lost   - sticky, lock dropped while running
//               wrap_count  - saturating wrap count for the current run
//               state_o     - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module demo_run_ctrl
    import demo_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int RUN_CYCLES    = 200,
    parameter int SYNC_STAGES   = 2,
    parameter int WRAP_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              ip_locked,
    input  logic [DEMO_W-1:0] demo_out,
    output logic              demo_enable,
    output logic              busy,
    output logic              done,
    output logic              lock_lost,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [2:0]        state_o
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES, RUN_CYCLES);

    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RUN_LAST    = CNT_W'(RUN_CYCLES - 1);

    // ------------------------------------------------------------------
    // Lock synchronizer: all lock decisions below use w_locked_s only.
    // ------------------------------------------------------------------
    logic w_locked_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ip_locked),
        .q     (w_locked_s)
    );

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] w_settle_cnt_nxt;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] w_run_cnt_nxt;
    logic             w_clear_stats;
    logic             w_set_lock_lost;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_run_cnt    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_run_cnt    <= w_run_cnt_nxt;
        end
    end

    // Stop is tested first in every active state so it dominates lock loss
    // and completion; in RUN, lock loss is tested before the terminal count.
    always_comb begin
        w_next_state     = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_run_cnt_nxt    = r_run_cnt;
        w_clear_stats    = 1'b0;
        w_set_lock_lost  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_next_state  = ST_WAIT_LOCK;
                    w_clear_stats = 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_locked_s) begin
                    w_next_state     = ST_SETTLE;
                    w_settle_cnt_nxt = '0;
                end
            end

            ST_SETTLE: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (!w_locked_s) begin
                    // Any lock glitch restarts the settle window from zero.
                    w_next_state     = ST_WAIT_LOCK;
                    w_settle_cnt_nxt = '0;
                end else if (r_settle_cnt == C_SETTLE_LAST) begin
                    w_next_state  = ST_RUN;
                    w_run_cnt_nxt = '0;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (!w_locked_s) begin
                    w_next_state    = ST_FAULT;
                    w_set_lock_lost = 1'b1;
                end else if (r_run_cnt == C_RUN_LAST) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_run_cnt_nxt = r_run_cnt + 1'b1;
                end
            end

            ST_DONE: begin
                w_next_state = ST_IDLE;
            end

            ST_FAULT: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (start) begin
                    w_next_state  = ST_WAIT_LOCK;
                    w_clear_stats = 1'b1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered enable: taken from next-state so it is high exactly for
    // the cycles the FSM sits in RUN and falls on the edge that leaves it.
    // ------------------------------------------------------------------
    logic r_demo_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_demo_enable <= 1'b0;
        end else begin
            r_demo_enable <= (w_next_state == ST_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Sticky lock-lost flag, cleared only when a new run is requested.
    // ------------------------------------------------------------------
    logic r_lock_lost;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_lost <= 1'b0;
        end else if (w_clear_stats) begin
            r_lock_lost <= 1'b0;
        end else if (w_set_lock_lost) begin
            r_lock_lost <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Wrap monitor. test_demo updates its output one cycle after the
    // enable that caused it, so the cycle after RUN is still watched to
    // catch a wrap produced by the final enabled cycle.
    // ------------------------------------------------------------------
    logic [DEMO_W-1:0] r_prev_out;
    logic              r_was_run;
    logic [WRAP_W-1:0] r_wrap_count;
    logic              w_wrap;

    assign w_wrap = (r_prev_out == WRAP_VAL) && (demo_out == '0) &&
                    ((r_state == ST_RUN) || r_was_run);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_out   <= '0;
            r_was_run    <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            r_prev_out <= demo_out;
            r_was_run  <= (r_state == ST_RUN);
            if (w_clear_stats) begin
                r_wrap_count <= '0;
            end else if (w_wrap && !(&r_wrap_count)) begin
                r_wrap_count <= r_wrap_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. busy/done decode the state register directly so they also
    // clear asynchronously with reset.
    // ------------------------------------------------------------------
    assign demo_enable = r_demo_enable;
    assign busy        = (r_state == ST_WAIT_LOCK) || (r_state == ST_SETTLE) ||
                         (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign lock_lost   = r_lock_lost;
    assign wrap_count  = r_wrap_count;
    assign state_o     = r_state;

endmodule : demo_run_ctrl
`default_nettype wire

// File: tb/tb_demo_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_demo_run_ctrl
// Description : Self-checking bench for demo_run_ctrl with SETTLE_CYCLES=4,
//               RUN_CYCLES=300, SYNC_STAGES=2. A small test_demo counter
//               model drives demo_out. Run scenarios come from a vector
//               table whose expectations are queued when each run starts and
//               compared when the run finishes; lock glitch, stop priority,
//               stop in FAULT and mid-run reset are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demo_run_ctrl;

    localparam int SETTLE = 4;
    localparam int RUNC   = 300;
    localparam int WW     = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          ip_locked;
    logic [7:0]    demo_out;
    logic          demo_enable;
    logic          busy;
    logic          done;
    logic          lock_lost;
    logic [WW-1:0] wrap_count;
    logic [2:0]    state_o;

    // test_demo stand-in: loadable 8-bit counter advancing on enable
    logic       load;
    logic [7:0] preset;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         lock_wait;   // cycles held unlocked after start (0 = already locked)
        int         abort_at;    // enabled cycles before stop pulse (-1 none)
        int         drop_at;     // enabled cycles before lock drop (-1 none)
        logic [7:0] pre;         // demo counter start value
        int         exp_lat;     // cycles from start/lock-raise to first enable
        int         exp_en;      // enabled cycles
        int         exp_done;    // done pulses
        int         exp_ll;      // lock_lost at end
        int         exp_wraps;   // wrap_count at end
        int         exp_state;   // state at end
    } vec_t;

    vec_t vecs[5];
    vec_t sb_q[$];

    demo_run_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .RUN_CYCLES    (RUNC),
        .SYNC_STAGES   (2),
        .WRAP_W        (WW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .ip_locked   (ip_locked),
        .demo_out    (demo_out),
        .demo_enable (demo_enable),
        .busy        (busy),
        .done        (done),
        .lock_lost   (lock_lost),
        .wrap_count  (wrap_count),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            demo_out <= 8'd0;
        else if (load)        demo_out <= preset;
        else if (demo_enable) demo_out <= demo_out + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_preset(input logic [7:0] v);
        preset = v;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   t, en_len, done_cnt, first_en, busy_err, hold_err, post, lim;
        bit   fin, prev_en, aborted, dropped, stop_pulse, ok;

        //             wait abort drop pre    lat  en   done ll wraps state
        vecs[0] = '{0,   -1,   -1,  8'h00, 6,  300, 1,   0, 1,    0};
        vecs[1] = '{50,  -1,   -1,  8'h00, 7,  300, 1,   0, 1,    0};
        vecs[2] = '{0,   -1,   100, 8'h00, 6,  102, 0,   1, 0,    5};
        vecs[3] = '{0,   -1,   -1,  8'hD4, 6,  300, 1,   0, 2,    0};
        vecs[4] = '{0,   10,   -1,  8'hFA, 6,  10,  0,   0, 1,    0};

        reset = 1'b1; start = 1'b0; stop = 1'b0; ip_locked = 1'b0;
        load = 1'b0; preset = 8'd0;
        tick(); tick();
        chk("rst_enable",   int'(demo_enable), 0);
        chk("rst_busy",     int'(busy),        0);
        chk("rst_done",     int'(done),        0);
        chk("rst_lock_lost",int'(lock_lost),   0);
        chk("rst_wraps",    int'(wrap_count),  0);
        chk("rst_state",    int'(state_o),     0);
        reset = 1'b0;
        tick();

        // ---------------- table-driven runs ----------------
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            ip_locked = (v.lock_wait == 0);
            tick(); tick(); tick();
            load_preset(v.pre);

            sb_q.push_back(v);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk($sformatf("v%0d_start_state", i), int'(state_o), 1);
            chk($sformatf("v%0d_start_clear", i), int'(lock_lost) + int'(wrap_count), 0);

            t = 1;
            hold_err = 0;
            if (v.lock_wait > 0) begin
                for (int k = 1; k < v.lock_wait; k++) begin
                    tick();
                    if (state_o != 3'd1 || !busy || demo_enable) hold_err++;
                end
                chk($sformatf("v%0d_wait_hold", i), hold_err, 0);
                ip_locked = 1'b1;
                t = 0;
            end

            en_len = 0; done_cnt = 0; first_en = -1; busy_err = 0;
            post = 0; lim = 0; fin = 0; prev_en = 0;
            aborted = 0; dropped = 0; stop_pulse = 0;
            while (!fin && lim < 1000) begin
                tick();
                t++; lim++;
                if (stop_pulse) begin stop = 1'b0; stop_pulse = 0; end
                if (demo_enable) begin
                    if (first_en < 0) first_en = t;
                    en_len++;
                    if (!busy) busy_err++;
                end
                if (done) done_cnt++;
                if (v.abort_at >= 0 && !aborted && en_len == v.abort_at) begin
                    stop = 1'b1; stop_pulse = 1; aborted = 1;
                end
                if (v.drop_at >= 0 && !dropped && en_len == v.drop_at) begin
                    ip_locked = 1'b0; dropped = 1;
                end
                if (post > 0) begin
                    post--;
                    if (post == 0) fin = 1;
                end else if (prev_en && !demo_enable) begin
                    post = 3;
                end
                prev_en = demo_enable;
            end
            stop = 1'b0;
            chk($sformatf("v%0d_timeout", i), int'(fin), 1);

            e = sb_q.pop_front();
            chk($sformatf("v%0d_latency", i),   first_en,          e.exp_lat);
            chk($sformatf("v%0d_en_len", i),    en_len,            e.exp_en);
            chk($sformatf("v%0d_done", i),      done_cnt,          e.exp_done);
            chk($sformatf("v%0d_lock_lost", i), int'(lock_lost),   e.exp_ll);
            chk($sformatf("v%0d_wraps", i),     int'(wrap_count),  e.exp_wraps);
            chk($sformatf("v%0d_state", i),     int'(state_o),     e.exp_state);
            chk($sformatf("v%0d_busy_run", i),  busy_err,          0);
        end

        // ---------------- start and stop together in IDLE ----------------
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_state", int'(state_o), 0);
        chk("startstop_busy",  int'(busy),    0);

        // ---------------- stop in WAIT_LOCK ----------------
        ip_locked = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("wait_state", int'(state_o), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("wait_stop_state", int'(state_o), 0);

        // ---------------- one-cycle lock glitch in SETTLE ----------------
        ip_locked = 1'b1;
        tick(); tick(); tick();
        start = 1'b1; tick(); start = 1'b0;        // t1 WAIT_LOCK
        tick();                                    // t2 SETTLE
        chk("glitch_settle", int'(state_o), 2);
        ip_locked = 1'b0; tick();                  // t3
        ip_locked = 1'b1; tick();                  // t4
        tick();                                    // t5 glitch reaches FSM
        chk("glitch_back_wait", int'(state_o), 1);
        hold_err = 0;
        for (int k = 6; k < 10; k++) begin
            tick();
            if (demo_enable) hold_err++;
        end
        chk("glitch_no_early_en", hold_err, 0);
        tick();                                    // t10
        chk("glitch_en_t10", int'(demo_enable), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("glitch_stop_state", int'(state_o), 0);
        chk("glitch_stop_en",    int'(demo_enable), 0);
        chk("glitch_stop_done",  int'(done), 0);

        // ---------------- lock loss then stop from FAULT ----------------
        start = 1'b1; tick(); start = 1'b0;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            if (demo_enable) ok = 1;
        end
        chk("fault_run_reached", int'(ok), 1);
        ip_locked = 1'b0;
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            tick();
            if (state_o == 3'd5) ok = 1;
        end
        chk("fault_reached", int'(ok), 1);
        chk("fault_en",      int'(demo_enable), 0);
        chk("fault_ll",      int'(lock_lost),   1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("fault_stop_state", int'(state_o), 0);
        chk("fault_stop_ll",    int'(lock_lost), 1);

        // ---------------- asynchronous reset mid-run ----------------
        ip_locked = 1'b1;
        tick(); tick(); tick();
        load_preset(8'hF0);
        start = 1'b1; tick(); start = 1'b0;
        en_len = 0; lim = 0;
        while (en_len < 50 && lim < 200) begin
            tick(); lim++;
            if (demo_enable) en_len++;
        end
        chk("rstmid_run50",  en_len, 50);
        chk("rstmid_wraps",  int'(wrap_count), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_en",    int'(demo_enable), 0);
        chk("rstmid_busy",  int'(busy),        0);
        chk("rstmid_wraps0",int'(wrap_count),  0);
        chk("rstmid_state", int'(state_o),     0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("rstmid_after_state", int'(state_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demo_run_ctrl
`default_nettype wire
